// File: rtl/divider32_pkg.sv
// Shared definitions for the iterative restoring divider: state encoding,
// iteration count, divide-by-zero constant and a conditional negate helper.
package divider32_pkg;

    localparam int          DIV_WIDTH    = 32;
    localparam int          ITERATIONS   = 32;
    localparam logic [31:0] DBZ_QUOTIENT = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } state_e;

    // Two's-complement negate mod 2^32 when en is set; also serves as abs().
    function automatic logic [31:0] neg_if(input logic [31:0] v, input logic en);
        return en ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/subtractor32.sv
// 32-bit subtractor with borrow in/out; the divider's trial subtraction unit.
module subtractor32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        borrow_in,
    output logic [31:0] diff,
    output logic        borrow_out
);

    assign {borrow_out, diff} = {1'b0, a} - {1'b0, b} - {32'b0, borrow_in};

endmodule

// File: rtl/divider32.sv
// Iterative signed/unsigned 32-bit restoring divider, one trial subtraction
// per clock. Handshake: start sampled in IDLE, busy while working, done pulses once.
module divider32
    import divider32_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    state_e           state_q, state_d;
    logic [4:0]       count_q, count_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [WIDTH-1:0] dividend_q, dividend_d;
    logic             neg_q_q, neg_q_d;
    logic             neg_r_q, neg_r_d;
    logic             dbz_q, dbz_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             div_by_zero_q, div_by_zero_d;

    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;
    logic             hi;
    logic             accept;

    assign shifted = {r_q[WIDTH-2:0], q_q[WIDTH-1]};
    assign hi      = r_q[WIDTH-1];

    subtractor32 u_sub (
        .a          (shifted),
        .b          (d_q),
        .borrow_in  (1'b0),
        .diff       (diff),
        .borrow_out (borrow_out)
    );

    // The bit shifted out of R makes the partial remainder 33 bits wide, so it always fits.
    assign accept = hi | ~borrow_out;

    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        q_d           = q_q;
        r_d           = r_q;
        d_d           = d_q;
        dividend_d    = dividend_q;
        neg_q_d       = neg_q_q;
        neg_r_d       = neg_r_q;
        dbz_d         = dbz_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        quotient_d    = quotient_q;
        remainder_d   = remainder_q;
        div_by_zero_d = div_by_zero_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    dividend_d = dividend;
                    neg_q_d    = signed_op & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                    neg_r_d    = signed_op & dividend[WIDTH-1];
                    q_d        = neg_if(dividend, signed_op & dividend[WIDTH-1]);
                    d_d        = neg_if(divisor, signed_op & divisor[WIDTH-1]);
                    r_d        = '0;
                    count_d    = '0;
                    dbz_d      = (divisor == '0);
                    busy_d     = 1'b1;
                    state_d    = (divisor == '0) ? ST_FIX : ST_RUN;
                end
            end
            ST_RUN: begin
                r_d     = accept ? diff : shifted;
                q_d     = {q_q[WIDTH-2:0], accept};
                count_d = count_q + 5'd1;
                if (count_q == 5'(ITERATIONS - 1)) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                if (dbz_q) begin
                    quotient_d    = DBZ_QUOTIENT;
                    remainder_d   = dividend_q;
                    div_by_zero_d = 1'b1;
                end else begin
                    quotient_d    = neg_if(q_q, neg_q_q);
                    remainder_d   = neg_if(r_q, neg_r_q);
                    div_by_zero_d = 1'b0;
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            count_q       <= '0;
            q_q           <= '0;
            r_q           <= '0;
            d_q           <= '0;
            dividend_q    <= '0;
            neg_q_q       <= 1'b0;
            neg_r_q       <= 1'b0;
            dbz_q         <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            quotient_q    <= '0;
            remainder_q   <= '0;
            div_by_zero_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            q_q           <= q_d;
            r_q           <= r_d;
            d_q           <= d_d;
            dividend_q    <= dividend_d;
            neg_q_q       <= neg_q_d;
            neg_r_q       <= neg_r_d;
            dbz_q         <= dbz_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            quotient_q    <= quotient_d;
            remainder_q   <= remainder_d;
            div_by_zero_q <= div_by_zero_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = div_by_zero_q;

endmodule
